// File: rtl/hc00_test_sequencer.sv
// hc00_test_sequencer
// Self-test controller for a quad 2-input NAND (hc00). Walks the four input
// combinations (a,b) = 00, 01, 10, 11 across all gates in parallel, holds
// each vector for SETTLE cycles, then samples gate_y for one CHECK cycle and
// accumulates a mismatch count and a per-gate fail mask. A run ends with a
// one-cycle done pulse and a pass flag; abort returns to IDLE without done.
module hc00_test_sequencer #(
    parameter int SETTLE = 3,
    parameter int NGATE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [NGATE-1:0] gate_a,
    output logic [NGATE-1:0] gate_b,
    input  logic [NGATE-1:0] gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [NGATE-1:0] fail_mask,
    output logic [1:0]       vec_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last value of the settle counter before moving to CHECK.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           r_state;
    logic [3:0]       r_settle;
    logic [NGATE-1:0] r_gate_a;
    logic [NGATE-1:0] r_gate_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [4:0]       r_err_cnt;
    logic [NGATE-1:0] r_fail_mask;
    logic [1:0]       r_vec_idx;

    logic [NGATE-1:0] w_expected;
    logic [NGATE-1:0] w_mism;
    logic [4:0]       w_err_next;
    logic [1:0]       w_vec_next;

    // Number of set bits in a mismatch vector; at most NGATE per vector.
    function automatic logic [4:0] popcount(input logic [NGATE-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NGATE; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Expected NAND response for the vector on the pins and the resulting
    // mismatch/count update used by CHECK.
    always_comb begin
        w_expected = {NGATE{~(r_vec_idx[1] & r_vec_idx[0])}};
        w_mism     = gate_y ^ w_expected;
        w_err_next = r_err_cnt + popcount(w_mism);
        w_vec_next = r_vec_idx + 2'd1;
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_gate_a    <= '0;
            r_gate_b    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_mask <= '0;
            r_vec_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_gate_a <= '0;
                    r_gate_b <= '0;
                    if (start) begin
                        // Vector 0 is (0,0), so the pins stay low on entry.
                        r_err_cnt   <= '0;
                        r_fail_mask <= '0;
                        r_pass      <= 1'b0;
                        r_vec_idx   <= '0;
                        r_settle    <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_gate_a  <= '0;
                        r_gate_b  <= '0;
                        r_vec_idx <= '0;
                        r_settle  <= '0;
                        r_pass    <= 1'b0;
                    end else if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end

                S_CHECK: begin
                    if (abort) begin
                        // Abort beats the final check: no done, no pass,
                        // and this cycle's sample is discarded.
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_gate_a  <= '0;
                        r_gate_b  <= '0;
                        r_vec_idx <= '0;
                        r_settle  <= '0;
                        r_pass    <= 1'b0;
                    end else begin
                        r_err_cnt   <= w_err_next;
                        r_fail_mask <= r_fail_mask | w_mism;
                        if (r_vec_idx == 2'd3) begin
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_gate_a  <= '0;
                            r_gate_b  <= '0;
                            r_vec_idx <= '0;
                            // Uses the count including this last vector.
                            r_pass    <= (w_err_next == 5'd0);
                        end else begin
                            r_vec_idx <= w_vec_next;
                            r_gate_a  <= {NGATE{w_vec_next[1]}};
                            r_gate_b  <= {NGATE{w_vec_next[0]}};
                            r_state   <= S_APPLY;
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not sampled here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gate_a    = r_gate_a;
    assign gate_b    = r_gate_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_mask = r_fail_mask;
    assign vec_idx   = r_vec_idx;

endmodule

// File: doc/hc00_test_sequencer.md
Name: hc00_test_sequencer

Overview:
- Self-test controller for the hc00 quad 2-input NAND.
- Drives every input combination to all four gates in parallel and waits a programmable settle time.
- Samples the four outputs, compares them against the expected NAND result, and reports pass/fail, an error count and a per-gate fail mask.
- Sits between a host/control FSM and the hc00 datapath. Four hc00 instances, or one quad model, connect directly to gate_a/gate_b/gate_y.

Parameters:
- SETTLE, 3: cycles each vector is held before sampling. Legal range 1..15.
- NGATE, 4: number of NAND gates driven in parallel. Fixed at 4 for hc00; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a test run; sampled only in IDLE
- abort  input  1  synchronous abort of a run in progress
- gate_a  output  4  A input to gates 3..0
- gate_b  output  4  B input to gates 3..0
- gate_y  input  4  output of gates 3..0 (NAND result under test)
- busy  output  1  high from the first APPLY cycle through the last CHECK cycle
- done  output  1  one-cycle pulse when a run completes; not raised on abort
- pass  output  1  1 when the last completed run had zero mismatches
- err_cnt  output  5  number of mismatching gate/vector pairs in the last run, 0..16
- fail_mask  output  4  bit g set if gate g mismatched on any vector in the last run
- vec_idx  output  2  index of the vector currently applied

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs take these values: gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, vec_idx=0. Settle counter=0.
- States: IDLE, APPLY, CHECK, DONE.
- Vector order, by vec_idx 0..3: (a,b) = 00, 01, 10, 11. a is vec_idx[1] and b is vec_idx[0], replicated to all four gates.
- Expected output per gate: ~(a&b), i.e. 1,1,1,0 for vectors 0..3.
- IDLE:
  - gate_a=gate_b=0.
  - start=1 at cycle t: clear err_cnt, fail_mask and pass; set vec_idx=0; go to APPLY.
- APPLY:
  - Drive the current vector and assert busy.
  - Stay for exactly SETTLE cycles (counter 0..SETTLE-1), then go to CHECK.
- CHECK (1 cycle):
  - Vector is still driven. Sample gate_y and form mism = gate_y ^ expected_vector.
  - err_cnt += popcount(mism); fail_mask |= mism.
  - If vec_idx=3, go to DONE. Otherwise increment vec_idx and go to APPLY; the next vector appears the following cycle.
- DONE (1 cycle):
  - done=1, busy=0, gate_a=gate_b=0, vec_idx=0.
  - pass = (err_cnt==0), using the final accumulated count.
  - Next state is IDLE.
- Timing: each vector occupies SETTLE+1 cycles. busy spans cycles t+1 .. t+4*(SETTLE+1). done pulses at t+4*(SETTLE+1)+1, which is t+17 for SETTLE=3.
- Result registers (pass, err_cnt, fail_mask) hold their values until the next accepted start or reset.
- err_cnt is 5 bits wide and cannot overflow (maximum 16).
- start while not in IDLE is ignored and has no effect on the run.
- start is also ignored in the DONE cycle; it is accepted in IDLE one cycle later.
- abort=1 in APPLY or CHECK:
  - Next cycle: state=IDLE, busy=0, gate_a=gate_b=0, vec_idx=0.
  - pass=0; done is not pulsed.
  - err_cnt and fail_mask keep their partial values.
- abort in IDLE or DONE has no effect.
- If abort and the final CHECK coincide, abort wins: no done and no pass.
- Reset mid-run: immediate return to the reset values above; no done pulse.
- gate_y is treated as synchronous to clk. The bench model must be combinational or settle within SETTLE cycles.

Test Plan:
- Ideal NAND model, SETTLE=3, start pulse at cycle t -> busy during t+1..t+16, done=1 only at t+17, pass=1, err_cnt=0, fail_mask=0000. The (gate_a,gate_b) sequence is 0/0, 0/F, F/0, F/F.
- gate_y[2] stuck at 0, others ideal -> err_cnt=3 (vectors 0,1,2), fail_mask=0100, pass=0.
- gate 0 modelled as AND, gate 3 stuck at 1 -> gate 0 contributes 4 errors and gate 3 contributes 1 (vector 3), so err_cnt=5, fail_mask=1001, pass=0.
- start re-pulsed at t+5 during a run -> the run completes unchanged with done at t+17; a second start at t+18 (IDLE) is accepted and gives identical results.
- abort asserted during the APPLY of vec_idx=2 -> next cycle busy=0, gate_a=gate_b=0, pass=0, no done pulse. A subsequent start gives a full pass.
- rst_n low for 2 cycles mid-run, then a new start; also run with SETTLE=1 and an ideal model -> all outputs at reset values while reset is low; with SETTLE=1, done at t+9, pass=1.
